// File: rtl/wb.sv
// Write-back stage: drives the register-file write port, owns HI/LO and the
// CP0 STATUS/CAUSE/EPC registers, and raises the syscall/eret redirect.
module wb (
  input  logic         clk,
  input  logic         resetn,
  input  logic         WB_valid,
  input  logic [117:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic [32:0]  exc_bus,
  output logic         cancel,
  output logic [31:0]  WB_pc,
  output logic [31:0]  HI_data,
  output logic [31:0]  LO_data
);

  localparam logic [31:0] EXC_ENTRY    = 32'h0000_0000;
  localparam logic [7:0]  CP0_STATUS   = 8'h60;
  localparam logic [7:0]  CP0_CAUSE    = 8'h68;
  localparam logic [7:0]  CP0_EPC      = 8'h70;
  localparam logic [4:0]  EXC_SYSCALL  = 5'd8;

  // Bus fields, MSB first
  logic        bus_rf_wen;
  logic [4:0]  bus_rf_wdest;
  logic [31:0] mem_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;
  logic        mfhi;
  logic        mflo;
  logic        mtc0;
  logic        mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall;
  logic        eret;
  logic [31:0] pc;

  assign bus_rf_wen   = MEM_WB_bus_r[117];
  assign bus_rf_wdest = MEM_WB_bus_r[116:112];
  assign mem_result   = MEM_WB_bus_r[111:80];
  assign lo_result    = MEM_WB_bus_r[79:48];
  assign hi_write     = MEM_WB_bus_r[47];
  assign lo_write     = MEM_WB_bus_r[46];
  assign mfhi         = MEM_WB_bus_r[45];
  assign mflo         = MEM_WB_bus_r[44];
  assign mtc0         = MEM_WB_bus_r[43];
  assign mfc0         = MEM_WB_bus_r[42];
  assign cp0r_addr    = MEM_WB_bus_r[41:34];
  assign syscall      = MEM_WB_bus_r[33];
  assign eret         = MEM_WB_bus_r[32];
  assign pc           = MEM_WB_bus_r[31:0];

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic [4:0]  cause_exc_q, cause_exc_d;

  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] cp0_rdata;
  logic        exc_valid;
  logic [31:0] exc_pc;

  assign status_rd = {16'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_rd  = {25'd0, cause_exc_q, 2'd0};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0r_addr)
      CP0_STATUS: cp0_rdata = status_rd;
      CP0_CAUSE:  cp0_rdata = cause_rd;
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    rf_wdata = mem_result;
    if (mfhi)      rf_wdata = hi_q;
    else if (mflo) rf_wdata = lo_q;
    else if (mfc0) rf_wdata = cp0_rdata;
  end

  // eret returns to the EPC held before this cycle's edge
  always_comb begin
    exc_valid = WB_valid & (syscall | eret);
    exc_pc    = 32'd0;
    if (WB_valid) begin
      if (syscall)   exc_pc = EXC_ENTRY;
      else if (eret) exc_pc = epc_q;
    end
  end

  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    epc_d        = epc_q;
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_exc_d  = cause_exc_q;
    if (WB_valid) begin
      if (hi_write) hi_d = mem_result;
      if (lo_write) lo_d = lo_result;
      if (syscall) begin
        epc_d        = pc;
        cause_exc_d  = EXC_SYSCALL;
        status_exl_d = 1'b1;
      end else if (eret) begin
        status_exl_d = 1'b0;
      end else if (mtc0) begin
        case (cp0r_addr)
          CP0_STATUS: begin
            status_im_d  = mem_result[15:8];
            status_exl_d = mem_result[1];
            status_ie_d  = mem_result[0];
          end
          CP0_EPC: epc_d = mem_result;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      epc_q        <= 32'd0;
      status_im_q  <= 8'd0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_exc_q  <= 5'd0;
    end else begin
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      epc_q        <= epc_d;
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_exc_q  <= cause_exc_d;
    end
  end

  assign rf_wen   = WB_valid & bus_rf_wen;
  assign rf_wdest = bus_rf_wdest;
  assign WB_over  = WB_valid;
  assign WB_wdest = bus_rf_wdest & {5{WB_valid}};
  assign exc_bus  = {exc_valid, exc_pc};
  assign cancel   = exc_valid;
  assign WB_pc    = pc;
  assign HI_data  = hi_q;
  assign LO_data  = lo_q;

endmodule

// File: tb/tb_wb.sv
// Directed bench for the write-back stage: register-file port, HI/LO,
// CP0 registers, syscall/eret redirect and asynchronous reset.
module tb_wb;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
  } bus_t;

  logic         clk;
  logic         resetn;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic [32:0]  exc_bus;
  logic         cancel;
  logic [31:0]  WB_pc;
  logic [31:0]  HI_data;
  logic [31:0]  LO_data;

  int checks = 0;
  int errors = 0;
  bus_t b;

  wb dut (
    .clk(clk), .resetn(resetn), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_bus(exc_bus), .cancel(cancel), .WB_pc(WB_pc),
    .HI_data(HI_data), .LO_data(LO_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction just after a rising edge; outputs settle 1 later.
  task automatic issue(input logic v, input bus_t bb);
    @(posedge clk);
    #1;
    WB_valid     = v;
    MEM_WB_bus_r = bb;
    #1;
  endtask

  task automatic rd_cp0(input logic [7:0] addr, input logic [4:0] dest);
    bus_t t;
    t = '0;
    t.rf_wen = 1'b1; t.rf_wdest = dest; t.mfc0 = 1'b1; t.cp0r_addr = addr;
    issue(1'b1, t);
  endtask

  initial begin
    resetn = 1'b0;
    WB_valid = 1'b0;
    MEM_WB_bus_r = '0;
    #12;
    check("reset_rf_wen", rf_wen, 0);
    check("reset_exc_bus", exc_bus, 0);
    check("reset_cancel", cancel, 0);
    check("reset_hi", HI_data, 0);
    check("reset_lo", LO_data, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Plain write, valid then invalid
    b = '0; b.rf_wen = 1; b.rf_wdest = 5; b.mem_result = 32'h1234_5678; b.pc = 32'h0000_0040;
    issue(1'b1, b);
    check("plain_rf_wen", rf_wen, 1);
    check("plain_rf_wdest", rf_wdest, 5);
    check("plain_rf_wdata", rf_wdata, 32'h1234_5678);
    check("plain_wb_wdest", WB_wdest, 5);
    check("plain_wb_over", WB_over, 1);
    check("plain_wb_pc", WB_pc, 32'h0000_0040);
    issue(1'b0, b);
    check("idle_rf_wen", rf_wen, 0);
    check("idle_wb_wdest", WB_wdest, 0);
    check("idle_wb_over", WB_over, 0);

    // HI/LO dual write then reads
    b = '0; b.hi_write = 1; b.lo_write = 1; b.mem_result = 32'hAAAA_0001; b.lo_result = 32'h5555_0002;
    issue(1'b1, b);
    check("mult_no_rf_wen", rf_wen, 0);
    b = '0; b.rf_wen = 1; b.rf_wdest = 3; b.mfhi = 1; b.mem_result = 32'hDEAD_BEEF;
    issue(1'b1, b);
    check("mfhi_data", rf_wdata, 32'hAAAA_0001);
    check("hi_display", HI_data, 32'hAAAA_0001);
    b.mfhi = 0; b.mflo = 1;
    issue(1'b1, b);
    check("mflo_data", rf_wdata, 32'h5555_0002);
    check("lo_display", LO_data, 32'h5555_0002);

    // syscall redirect and CP0 side effects
    b = '0; b.syscall = 1; b.pc = 32'hBFC0_0100;
    issue(1'b1, b);
    check("syscall_exc_bus", exc_bus, {1'b1, 32'h0000_0000});
    check("syscall_cancel", cancel, 1);
    rd_cp0(8'h70, 5'd4);
    check("syscall_epc", rf_wdata, 32'hBFC0_0100);
    check("syscall_no_exc", exc_bus, 0);
    rd_cp0(8'h68, 5'd4);
    check("syscall_cause", rf_wdata, 32'h0000_0020);
    rd_cp0(8'h60, 5'd4);
    check("syscall_status", rf_wdata, 32'h0000_0002);

    // mtc0 EPC then eret uses the new EPC
    b = '0; b.mtc0 = 1; b.cp0r_addr = 8'h70; b.mem_result = 32'h0000_0400;
    issue(1'b1, b);
    check("mtc0_no_exc", exc_bus, 0);
    b = '0; b.eret = 1;
    issue(1'b1, b);
    check("eret_exc_bus", exc_bus, {1'b1, 32'h0000_0400});
    check("eret_cancel", cancel, 1);
    rd_cp0(8'h60, 5'd6);
    check("eret_status", rf_wdata, 32'h0000_0000);

    // STATUS write mask, CAUSE read-only, unmapped address
    b = '0; b.mtc0 = 1; b.cp0r_addr = 8'h60; b.mem_result = 32'hFFFF_FFFF;
    issue(1'b1, b);
    rd_cp0(8'h60, 5'd6);
    check("status_mask", rf_wdata, 32'h0000_FF03);
    b = '0; b.mtc0 = 1; b.cp0r_addr = 8'h68; b.mem_result = 32'h1234_5678;
    issue(1'b1, b);
    rd_cp0(8'h68, 5'd6);
    check("cause_ro", rf_wdata, 32'h0000_0020);
    rd_cp0(8'h00, 5'd6);
    check("cp0_unmapped", rf_wdata, 32'h0000_0000);

    // syscall with EXL already set overwrites EPC
    b = '0; b.syscall = 1; b.pc = 32'h0000_1000;
    issue(1'b1, b);
    check("syscall2_exc", exc_bus, {1'b1, 32'h0000_0000});
    rd_cp0(8'h70, 5'd7);
    check("syscall2_epc", rf_wdata, 32'h0000_1000);

    // Invalid syscall/eret: no redirect, no state change
    b = '0; b.syscall = 1; b.eret = 1; b.pc = 32'h0000_2000; b.hi_write = 1; b.mem_result = 32'h7777_7777;
    issue(1'b0, b);
    check("invalid_exc_bus", exc_bus, 0);
    check("invalid_cancel", cancel, 0);
    rd_cp0(8'h70, 5'd7);
    check("invalid_epc_kept", rf_wdata, 32'h0000_1000);
    check("invalid_hi_kept", HI_data, 32'hAAAA_0001);

    // Mid-stream asynchronous reset
    b = '0; b.hi_write = 1; b.mem_result = 32'h0BAD_F00D;
    issue(1'b1, b);
    @(posedge clk);
    #1;
    check("pre_reset_hi", HI_data, 32'h0BAD_F00D);
    WB_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_hi", HI_data, 0);
    check("async_lo", LO_data, 0);
    check("async_no_exc", exc_bus, 0);
    @(negedge clk);
    resetn = 1'b1;
    rd_cp0(8'h70, 5'd8);
    check("post_reset_epc", rf_wdata, 0);
    rd_cp0(8'h60, 5'd8);
    check("post_reset_status", rf_wdata, 0);
    rd_cp0(8'h68, 5'd8);
    check("post_reset_cause", rf_wdata, 0);
    b = '0; b.rf_wen = 1; b.rf_wdest = 9; b.mfhi = 1;
    issue(1'b1, b);
    check("post_reset_mfhi", rf_wdata, 0);
    b.mfhi = 0; b.mflo = 1;
    issue(1'b1, b);
    check("post_reset_mflo", rf_wdata, 0);

    @(posedge clk);
    #1;
    WB_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
